// File: rtl/mod_exp_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_if
// Brief    : Request/response bundle for the modular exponentiation engine.
//            master = requester (message source), slave = engine.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_exp_if #(
    parameter int WIDTH = 32
);
    localparam int K = 2 * WIDTH;

    logic         start;
    logic [K-1:0] msg;
    logic [K-1:0] exp;
    logic [K-1:0] n;
    logic         busy;
    logic         done;
    logic         err;
    logic [K-1:0] result;

    modport master (
        output start, msg, exp, n,
        input  busy, done, err, result
    );

    modport slave (
        input  start, msg, exp, n,
        output busy, done, err, result
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp
// Brief    : Iterative, multiplier-free modular exponentiation
//            result = msg^exp mod n. Right-to-left square-and-multiply over
//            interleaved shift-add modular multiplication (one bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module mod_exp #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mod_exp_if.slave    bus
);
    localparam int K     = 2 * WIDTH;
    localparam int CNT_W = $clog2(K);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(K - 1);
    localparam logic [K-1:0]     C_ONE     = K'(1);
    localparam logic [K-1:0]     C_TWO     = K'(2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_MUL  = 3'd2,
        S_SQR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [K-1:0]     r_base;
    logic [K-1:0]     r_e_sh;
    logic [K-1:0]     r_n;
    logic [K-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [K-1:0]     r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_reject;
    logic [K-1:0]     w_a;
    logic [K-1:0]     w_b;
    logic             w_bit;
    logic [K:0]       w_n_ext;
    logic [K:0]       w_dbl;
    logic [K:0]       w_red1;
    logic [K:0]       w_add;
    logic [K-1:0]     w_t;

    // Operand screening on the live inputs, used only at acceptance
    assign w_reject = (bus.n < C_TWO) || (bus.msg >= bus.n);

    // One step of the interleaved shift-add modular multiply a*b mod n.
    // In MUL the multiplicand is the running result, in SQR it is the base;
    // neither register changes until the final step, so both stay frozen.
    always_comb begin
        w_a     = (r_state == S_MUL) ? r_result : r_base;
        w_b     = r_base;
        w_bit   = w_b[r_cnt];
        w_n_ext = {1'b0, r_n};
        w_dbl   = {r_acc, 1'b0};
        w_red1  = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        w_add   = w_red1 + (w_bit ? {1'b0, w_a} : {(K+1){1'b0}});
        w_t     = (w_add >= w_n_ext) ? K'(w_add - w_n_ext) : w_add[K-1:0];
    end

    // Control FSM and datapath registers with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_e_sh   <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n    <= bus.n;
                        r_base <= bus.msg;
                        r_busy <= 1'b1;
                        // Rejected requests take the same single SCAN step as
                        // exp = 0 (empty exponent), giving a uniform N = 1.
                        if (w_reject) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                            r_e_sh   <= '0;
                        end else begin
                            r_err    <= 1'b0;
                            r_result <= C_ONE;
                            r_e_sh   <= bus.exp;
                        end
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_e_sh == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc   <= '0;
                        r_cnt   <= C_CNT_MAX;
                        r_state <= r_e_sh[0] ? S_MUL : S_SQR;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_result <= w_t;
                        r_acc    <= '0;
                        r_cnt    <= C_CNT_MAX;
                        r_state  <= S_SQR;
                    end else begin
                        r_acc <= w_t;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SQR: begin
                    if (r_cnt == '0) begin
                        r_base  <= w_t;
                        r_e_sh  <= r_e_sh >> 1;
                        r_acc   <= '0;
                        r_state <= S_SCAN;
                    end else begin
                        r_acc <= w_t;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_exp
// Brief    : Self-checking bench for mod_exp with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_exp;
    localparam int WIDTH = 32;
    localparam int K     = 2 * WIDTH;

    typedef struct {
        logic [K-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   t0;
    int   last_lat;
    int   total;
    int   bad;
    exp_t sb[$];

    mod_exp_if #(.WIDTH(WIDTH)) bus ();

    mod_exp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [K-1:0] ref_modexp(input logic [K-1:0] m, input logic [K-1:0] e,
                                                input logic [K-1:0] nn);
        logic [2*K-1:0] r, b, nw;
        nw = {{K{1'b0}}, nn};
        r  = 1;
        b  = {{K{1'b0}}, m};
        for (int i = 0; i < K; i++) begin
            if (e[i]) r = (r * b) % nw;
            b = (b * b) % nw;
        end
        return r[K-1:0];
    endfunction

    function automatic int ref_lat(input logic [K-1:0] e, input logic rej);
        int h;
        int w;
        h = 0;
        if (rej || e == '0) return 1;
        for (int i = 0; i < K; i++) if (e[i]) h = i;
        w = $countones(e);
        return 1 + (h + 1) * (K + 1) + w * K;
    endfunction

    // Drive one request; expectation is queued at the moment of issue
    task automatic issue(input logic [K-1:0] m, input logic [K-1:0] e, input logic [K-1:0] nn);
        exp_t x;
        x.err = (nn < 2) || (m >= nn);
        x.res = x.err ? '0 : ref_modexp(m, e, nn);
        x.lat = ref_lat(e, x.err);
        sb.push_back(x);
        @(negedge clk);
        bus.msg   = m;
        bus.exp   = e;
        bus.n     = nn;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0        = cyc;
        bus.start = 1'b0;
        bus.msg   = {$urandom, $urandom};
        bus.exp   = {$urandom, $urandom};
        bus.n     = {$urandom, $urandom};
    endtask

    // Wait for done, pop the oldest expectation and compare
    task automatic finish_op(input string tag);
        exp_t x;
        int   k;
        k = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        x = sb.pop_front();
        if (bus.done !== 1'b1) begin
            chk({tag, "_timeout"}, '0, 1);
        end else begin
            last_lat = cyc - t0;
            chk({tag, "_result"}, bus.result, x.res);
            chk({tag, "_err"}, K'(bus.err), K'(x.err));
            chk({tag, "_latency"}, K'(last_lat), K'(x.lat));
            chk({tag, "_busy_at_done"}, K'(bus.busy), 1);
            @(negedge clk);
            chk({tag, "_done_width"}, K'(bus.done), 0);
            chk({tag, "_busy_after"}, K'(bus.busy), 0);
        end
    endtask

    initial begin
        exp_t         drop;
        int           ndone;
        logic [K-1:0] rn, rm, re;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.msg   = '0;
        bus.exp   = '0;
        bus.n     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", K'(bus.busy), 0);
        chk("reset_done", K'(bus.done), 0);
        chk("reset_err", K'(bus.err), 0);
        chk("reset_result", bus.result, 0);
        reset = 1'b0;

        // RSA round trip
        issue(64'd65, 64'd17, 64'd3233);
        finish_op("rsa_enc");
        chk("rsa_enc_454", K'(last_lat), 454);
        chk("rsa_enc_2790", bus.result, 64'd2790);
        issue(64'd2790, 64'd2753, 64'd3233);
        finish_op("rsa_dec");
        chk("rsa_dec_65", bus.result, 64'd65);

        // Degenerate exponent and base
        issue(64'd1234, 64'd0, 64'd3233);
        finish_op("exp_zero");
        chk("exp_zero_n1", K'(last_lat), 1);
        issue(64'd0, 64'd17, 64'd3233);
        finish_op("msg_zero");

        // Operand rejection, then recovery
        issue(64'd5, 64'd17, 64'd1);
        finish_op("rej_n1");
        chk("rej_n1_err", K'(bus.err), 1);
        issue(64'd3233, 64'd17, 64'd3233);
        finish_op("rej_msg_eq_n");
        issue(64'd65, 64'd17, 64'd3233);
        finish_op("after_rej");
        chk("after_rej_err_clear", K'(bus.err), 0);

        // start during MUL is ignored
        issue(64'd65, 64'd17, 64'd3233);
        repeat (30) @(negedge clk);
        bus.msg   = 64'd7;
        bus.exp   = 64'd3;
        bus.n     = 64'd11;
        bus.start = 1'b1;
        chk("busy_during_mul", K'(bus.busy), 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_op("busy_first");
        issue(64'd7, 64'd3, 64'd11);
        finish_op("busy_second");

        // Reset in the middle of SQR
        issue(64'd65, 64'd17, 64'd3233);
        repeat (80) @(negedge clk);
        reset = 1'b1;
        #1;
        drop = sb.pop_front();
        chk("abort_busy", K'(bus.busy), 0);
        chk("abort_done", K'(bus.done), 0);
        chk("abort_err", K'(bus.err), 0);
        chk("abort_result", bus.result, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("abort_no_done", K'(ndone), 0);
        issue(64'd65, 64'd17, 64'd3233);
        finish_op("after_abort");
        chk("after_abort_454", K'(last_lat), 454);

        // Full-width random operands, full-width exponents
        for (int i = 0; i < 5; i++) begin
            rn = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
            rm = {$urandom, $urandom} % rn;
            re = {$urandom, $urandom};
            issue(rm, re, rn);
            finish_op("rand_full");
        end
        // Full-width random operands, short exponents
        for (int i = 0; i < 10; i++) begin
            rn = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
            rm = {$urandom, $urandom} % rn;
            re = K'($urandom_range(1, 4095));
            issue(rm, re, rn);
            finish_op("rand_short");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
